// File: rtl/hit_memory_readout.sv
// hit_memory_readout: scans the HitsNewMemory rows and, for each set bit in
// ascending SSID order, fetches the HitsCountMemory word and emits one
// {SSID, hit count, HLM address} record on a valid/ready stream.
// Optional feature macro: READOUT_CLEAR_EN (clears each HNM row that produced
// records, on the SCAN cycle that finishes that row).
module hit_memory_readout #(
   parameter int unsigned COLINDEXBITS_HNM = 4,
   parameter int unsigned ROWINDEXBITS_HNM = 4,
   parameter int unsigned SSIDBITS         = 8,
   parameter int unsigned NCOLS_HCM        = 16,
   parameter int unsigned ROWINDEXBITS_HLM = 8,
   parameter int unsigned MAXHITNBITS      = 4
) (
   input  logic                              clock,
   input  logic                              resetN,
   input  logic                              startRead,
   output logic                              readBusy,
   output logic                              readDone,
   output logic [ROWINDEXBITS_HNM-1:0]       rowIndex_HNM,
   input  logic [(2**COLINDEXBITS_HNM)-1:0]  dataOutput_HNM,
   output logic [SSIDBITS-1:0]               rowIndex_HCM,
   input  logic [NCOLS_HCM-1:0]              dataOutput_HCM,
   output logic                              outValid,
   input  logic                              outReady,
   output logic [SSIDBITS-1:0]               outSSID,
   output logic [MAXHITNBITS-1:0]            outHitCount,
   output logic [ROWINDEXBITS_HLM-1:0]       outHLMAddress
`ifdef READOUT_CLEAR_EN
   ,
   output logic                              writeEnable_HNM,
   output logic [(2**COLINDEXBITS_HNM)-1:0]  dataInput_HNM
`endif
);

   localparam int unsigned NCOLS_HNM = 2**COLINDEXBITS_HNM;
   localparam int unsigned NROWS_HNM = 2**ROWINDEXBITS_HNM;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ROWREQ   = 3'd1;
   localparam logic [2:0] S_ROWLATCH = 3'd2;
   localparam logic [2:0] S_SCAN     = 3'd3;
   localparam logic [2:0] S_HCMREQ   = 3'd4;
   localparam logic [2:0] S_HCMLATCH = 3'd5;
   localparam logic [2:0] S_EMIT     = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   logic [2:0]                  r_state,    w_state_nxt;
   logic [ROWINDEXBITS_HNM-1:0] r_row,      w_row_nxt;
   logic [NCOLS_HNM-1:0]        r_mask,     w_mask_nxt;
   logic                        r_busy,     w_busy_nxt;
   logic                        r_done,     w_done_nxt;
   logic [SSIDBITS-1:0]         r_hcm_addr, w_hcm_addr_nxt;
   logic                        r_valid,    w_valid_nxt;
   logic [SSIDBITS-1:0]         r_ssid,     w_ssid_nxt;
   logic [MAXHITNBITS-1:0]      r_cnt,      w_cnt_nxt;
   logic [ROWINDEXBITS_HLM-1:0] r_hlm,      w_hlm_nxt;
   logic [COLINDEXBITS_HNM-1:0] w_col;
   logic                        w_unused_hcm;

   // Middle HCM bits between the count and address fields carry nothing for us.
   assign w_unused_hcm = ^dataOutput_HCM;

   // Lowest set bit of the pending row mask (scan from the top so the lowest wins).
   always_comb begin
      w_col = '0;
      for (int i = int'(NCOLS_HNM) - 1; i >= 0; i--) begin
         if (r_mask[i]) w_col = COLINDEXBITS_HNM'(i);
      end
   end

   // Next-state and next-register logic for the scan.
   always_comb begin
      w_state_nxt    = r_state;
      w_row_nxt      = r_row;
      w_mask_nxt     = r_mask;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_hcm_addr_nxt = r_hcm_addr;
      w_valid_nxt    = r_valid;
      w_ssid_nxt     = r_ssid;
      w_cnt_nxt      = r_cnt;
      w_hlm_nxt      = r_hlm;
      case (r_state)
         S_IDLE: begin
            if (startRead) begin
               w_row_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_ROWREQ;
            end
         end
         S_ROWREQ:   w_state_nxt = S_ROWLATCH;
         S_ROWLATCH: begin
            w_mask_nxt  = dataOutput_HNM;
            w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (r_mask == '0) begin
               if (r_row == ROWINDEXBITS_HNM'(NROWS_HNM - 1)) begin
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_row_nxt   = r_row + ROWINDEXBITS_HNM'(1);
                  w_state_nxt = S_ROWREQ;
               end
            end else begin
               w_mask_nxt     = r_mask & (r_mask - NCOLS_HNM'(1));
               w_hcm_addr_nxt = SSIDBITS'({r_row, w_col});
               w_state_nxt    = S_HCMREQ;
            end
         end
         S_HCMREQ:   w_state_nxt = S_HCMLATCH;
         S_HCMLATCH: begin
            w_ssid_nxt  = r_hcm_addr;
            w_cnt_nxt   = dataOutput_HCM[MAXHITNBITS-1:0];
            w_hlm_nxt   = dataOutput_HCM[NCOLS_HCM-1 -: ROWINDEXBITS_HLM];
            w_valid_nxt = 1'b1;
            w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (outReady) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_SCAN;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any scan in progress.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_mask     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_hcm_addr <= '0;
         r_valid    <= 1'b0;
         r_ssid     <= '0;
         r_cnt      <= '0;
         r_hlm      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_row      <= w_row_nxt;
         r_mask     <= w_mask_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_hcm_addr <= w_hcm_addr_nxt;
         r_valid    <= w_valid_nxt;
         r_ssid     <= w_ssid_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hlm      <= w_hlm_nxt;
      end
   end

   assign readBusy      = r_busy;
   assign readDone      = r_done;
   assign rowIndex_HNM  = r_row;
   assign rowIndex_HCM  = r_hcm_addr;
   assign outValid      = r_valid;
   assign outSSID       = r_ssid;
   assign outHitCount   = r_cnt;
   assign outHLMAddress = r_hlm;

`ifdef READOUT_CLEAR_EN
   logic r_we;

   // A row that emitted records reaches SCAN with an empty mask only straight
   // out of EMIT, so arm the clear on the accepting handshake of its last bit.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_we <= 1'b0;
      else         r_we <= (r_state == S_EMIT) && outReady && (r_mask == '0);
   end

   assign writeEnable_HNM = r_we;
   assign dataInput_HNM   = '0;
`else
   // HNM port B stays read-only in this build.
`endif

endmodule

// File: tb/tb_hit_memory_readout.sv
// Directed bench for hit_memory_readout with behavioural HNM/HCM RAM models.
// Build with READOUT_CLEAR_EN defined to also exercise the row-clear feature.
module tb_hit_memory_readout;

   logic        clock;
   logic        resetN;
   logic        startRead;
   logic        readBusy;
   logic        readDone;
   logic [3:0]  rowIndex_HNM;
   logic [15:0] dataOutput_HNM;
   logic [7:0]  rowIndex_HCM;
   logic [15:0] dataOutput_HCM;
   logic        outValid;
   logic        outReady;
   logic [7:0]  outSSID;
   logic [3:0]  outHitCount;
   logic [7:0]  outHLMAddress;
`ifdef READOUT_CLEAR_EN
   logic        writeEnable_HNM;
   logic [15:0] dataInput_HNM;
`endif

   hit_memory_readout dut (
      .clock          (clock),
      .resetN         (resetN),
      .startRead      (startRead),
      .readBusy       (readBusy),
      .readDone       (readDone),
      .rowIndex_HNM   (rowIndex_HNM),
      .dataOutput_HNM (dataOutput_HNM),
      .rowIndex_HCM   (rowIndex_HCM),
      .dataOutput_HCM (dataOutput_HCM),
      .outValid       (outValid),
      .outReady       (outReady),
      .outSSID        (outSSID),
      .outHitCount    (outHitCount),
      .outHLMAddress  (outHLMAddress)
`ifdef READOUT_CLEAR_EN
      ,
      .writeEnable_HNM(writeEnable_HNM),
      .dataInput_HNM  (dataInput_HNM)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM models: 1-cycle read latency; HNM loaded by the bench through ld_*
   logic [15:0] hnm [16];
   logic [15:0] hcm [256];
   logic        ld_en;
   logic [3:0]  ld_row;
   logic [15:0] ld_val;

   always @(posedge clock) begin
      dataOutput_HNM <= hnm[rowIndex_HNM];
      dataOutput_HCM <= hcm[rowIndex_HCM];
      if (ld_en) hnm[ld_row] <= ld_val;
`ifdef READOUT_CLEAR_EN
      else if (writeEnable_HNM) hnm[rowIndex_HNM] <= dataInput_HNM;
`endif
   end

   int checks   = 0;
   int failures = 0;

   // Scan observation results
   logic [7:0]  got_ssid [8];
   logic [3:0]  got_cnt  [8];
   logic [7:0]  got_hlm  [8];
   int          got_n;
   int          busy_n;
   int          done_at;
   logic        first_busy;
   logic [3:0]  first_row;
   logic        post_busy;
   int          stall_cnt;
   int          hold_err;
   int          we_n;
   logic [3:0]  we_row [4];
   logic [15:0] we_data_or;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_row(input int r, input logic [15:0] v);
      ld_row = 4'(r);
      ld_val = v;
      ld_en  = 1'b1;
      @(posedge clock);
      #1;
      ld_en  = 1'b0;
   endtask

   task automatic clear_hnm();
      for (int r = 0; r < 16; r++) load_row(r, 16'h0000);
   endtask

   // One full readout; stall_rec = record index to backpressure for 5 cycles.
   task automatic run_scan(input int stall_rec, input bit mid_start);
      int          cyc;
      logic        prev_v;
      logic        prev_hs;
      logic [19:0] held;
      got_n = 0; busy_n = 0; done_at = -1; stall_cnt = 0; hold_err = 0;
      we_n = 0; we_data_or = '0; held = '0;
      prev_v = 1'b0; prev_hs = 1'b0;
      @(negedge clock);
      startRead = 1'b1;
      @(negedge clock);
      startRead  = 1'b0;
      cyc        = 1;
      first_busy = readBusy;
      first_row  = rowIndex_HNM;
      while (done_at < 0 && cyc < 2000) begin
         startRead = mid_start && (cyc == 10);
         if (readBusy) busy_n++;
`ifdef READOUT_CLEAR_EN
         if (writeEnable_HNM) begin
            if (we_n < 4) we_row[we_n] = rowIndex_HNM;
            we_data_or = we_data_or | dataInput_HNM;
            we_n++;
         end
`endif
         if (prev_v && !prev_hs && !outValid) hold_err++;
         if (outValid) begin
            if (got_n == stall_rec && stall_cnt < 5) begin
               if (stall_cnt == 0) held = {outSSID, outHitCount, outHLMAddress};
               else if ({outSSID, outHitCount, outHLMAddress} !== held) hold_err++;
               stall_cnt++;
               outReady = 1'b0;
            end else begin
               if (got_n == stall_rec && {outSSID, outHitCount, outHLMAddress} !== held) hold_err++;
               outReady = 1'b1;
               if (got_n < 8) begin
                  got_ssid[got_n] = outSSID;
                  got_cnt[got_n]  = outHitCount;
                  got_hlm[got_n]  = outHLMAddress;
               end
               got_n++;
            end
         end else begin
            outReady = 1'b1;
         end
         prev_v  = outValid;
         prev_hs = outValid && outReady;
         if (readDone) begin
            done_at   = cyc;
            startRead = 1'b1;
         end
         @(negedge clock);
         cyc++;
      end
      startRead = 1'b0;
      outReady  = 1'b1;
      post_busy = readBusy;
      repeat (3) begin
         @(negedge clock);
         post_busy = post_busy | readBusy;
      end
   endtask

   initial begin
      int          n;
      logic [15:0] hnm_or;
      resetN    = 1'b0;
      startRead = 1'b0;
      outReady  = 1'b1;
      ld_en     = 1'b0;
      ld_row    = '0;
      ld_val    = '0;
      for (int a = 0; a < 256; a++) hcm[a] = 16'h0000;
      for (int r = 0; r < 16; r++) hnm[r] = 16'h0000;
      hcm[8'h00] = 16'hA000;
      hcm[8'h0F] = 16'h1F0E;
      hcm[8'h23] = 16'h0503;
      hcm[8'hF0] = 16'hFF07;
      repeat (3) @(negedge clock);
      chk("reset_ctrl_data", 32'({readBusy, readDone, outValid, outSSID, outHitCount, outHLMAddress}), 32'h0);
      chk("reset_addr", 32'({rowIndex_HNM, rowIndex_HCM}), 32'h0);
      resetN = 1'b1;
      clear_hnm();

      // Empty memory, plus startRead during the DONE cycle
      run_scan(-1, 1'b0);
      chk("empty_first_busy", 32'(first_busy), 32'h1);
      chk("empty_first_row", 32'(first_row), 32'h0);
      chk("empty_records", 32'(got_n), 32'd0);
      chk("empty_done_cycle", 32'(done_at), 32'd49);
      chk("empty_busy_cycles", 32'(busy_n), 32'd48);
      chk("empty_restart_ignored", 32'(post_busy), 32'h0);

      // Single hit, with a startRead mid-scan that must be ignored
      load_row(2, 16'h0008);
      run_scan(-1, 1'b1);
      chk("single_records", 32'(got_n), 32'd1);
      chk("single_ssid", 32'(got_ssid[0]), 32'h23);
      chk("single_count", 32'(got_cnt[0]), 32'h3);
      chk("single_hlm", 32'(got_hlm[0]), 32'h05);
      chk("single_done_cycle", 32'(done_at), 32'd53);

      // Three hits across the first and last rows, including a zero count
      load_row(2, 16'h0000);
      load_row(0, 16'h8001);
      load_row(15, 16'h0001);
      run_scan(-1, 1'b0);
      chk("three_records", 32'(got_n), 32'd3);
      chk("three_ssid0", 32'(got_ssid[0]), 32'h00);
      chk("three_count0", 32'(got_cnt[0]), 32'h0);
      chk("three_hlm0", 32'(got_hlm[0]), 32'hA0);
      chk("three_ssid1", 32'(got_ssid[1]), 32'h0F);
      chk("three_count1", 32'(got_cnt[1]), 32'hE);
      chk("three_hlm1", 32'(got_hlm[1]), 32'h1F);
      chk("three_ssid2", 32'(got_ssid[2]), 32'hF0);
      chk("three_count2", 32'(got_cnt[2]), 32'h7);
      chk("three_hlm2", 32'(got_hlm[2]), 32'hFF);
      chk("three_done_cycle", 32'(done_at), 32'd61);
      chk("three_valid_drop", 32'(hold_err), 32'd0);

      // Backpressure on the second record
      run_scan(1, 1'b0);
      chk("bp_stall_applied", 32'(stall_cnt), 32'd5);
      chk("bp_hold_stable", 32'(hold_err), 32'd0);
      chk("bp_records", 32'(got_n), 32'd3);
      chk("bp_ssid1", 32'(got_ssid[1]), 32'h0F);
      chk("bp_ssid2", 32'(got_ssid[2]), 32'hF0);
      chk("bp_done_cycle", 32'(done_at), 32'd66);

      // Reset mid-scan after the first record is accepted
      @(negedge clock);
      startRead = 1'b1;
      @(negedge clock);
      startRead = 1'b0;
      outReady  = 1'b1;
      n = 0;
      while (!outValid && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk("rst_first_valid_seen", 32'(outValid), 32'h1);
      @(negedge clock);
      resetN = 1'b0;
      #1;
      chk("rst_mid_ctrl_data", 32'({readBusy, readDone, outValid, outSSID, outHitCount, outHLMAddress}), 32'h0);
      chk("rst_mid_addr", 32'({rowIndex_HNM, rowIndex_HCM}), 32'h0);
      @(negedge clock);
      chk("rst_mid_no_done", 32'(readDone), 32'h0);
      resetN = 1'b1;
      run_scan(-1, 1'b0);
      chk("rst_rescan_records", 32'(got_n), 32'd3);
      chk("rst_rescan_ssid0", 32'(got_ssid[0]), 32'h00);
      chk("rst_rescan_ssid2", 32'(got_ssid[2]), 32'hF0);
      chk("rst_rescan_done_cycle", 32'(done_at), 32'd61);

`ifdef READOUT_CLEAR_EN
      // Row clear: hits in rows 2 and 7 only
      clear_hnm();
      load_row(2, 16'h0011);
      load_row(7, 16'h0100);
      run_scan(-1, 1'b0);
      chk("clr_records", 32'(got_n), 32'd3);
      chk("clr_we_pulses", 32'(we_n), 32'd2);
      chk("clr_we_row0", 32'(we_row[0]), 32'h2);
      chk("clr_we_row1", 32'(we_row[1]), 32'h7);
      chk("clr_we_data", 32'(we_data_or), 32'h0);
      chk("clr_done_cycle", 32'(done_at), 32'd61);
      hnm_or = '0;
      for (int r = 0; r < 16; r++) hnm_or = hnm_or | hnm[r];
      chk("clr_hnm_empty", 32'(hnm_or), 32'h0);
      run_scan(-1, 1'b0);
      chk("clr_second_records", 32'(got_n), 32'd0);
      chk("clr_second_we", 32'(we_n), 32'd0);
`else
      hnm_or = '0;
      for (int r = 0; r < 16; r++) hnm_or = hnm_or | hnm[r];
      chk("noclr_hnm_kept", 32'(hnm_or), 32'h8001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
